// File: rtl/scroll_scan_ctrl_pkg.sv
// Shared types/constants for the scrolling display controller.
// Holds the run/stop state enum, anode-off pattern and offset width.
package scroll_scan_ctrl_pkg;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [3:0] ANODE_OFF = 4'b1111;
  localparam int         OFS_W     = 4;

endpackage

// File: rtl/scroll_scan_ctrl_tick_div.sv
// Modulo-N counter: en advances, clr zeroes, tc pulses at N-1.
// Ports: clk, reset, en, clr in; cnt (count), tc (terminal) out.
module tick_div #(
  parameter  int N = 8,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         tc
);

  localparam logic [W-1:0] LAST = W'(N - 1);

  logic at_last;

  assign at_last = (cnt == LAST);
  assign tc      = en && at_last;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= at_last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/scroll_scan_ctrl.sv
// Scroll offset + 4-digit scan sequencer; offset commits on frame wrap.
// In: clk, reset, run, dir, step, load. Out: offset, digit_sel, anode, blank.
module scroll_scan_ctrl
  import scroll_scan_ctrl_pkg::*;
#(
  parameter int SCROLL_DIV = 50_000_000,
  parameter int SCAN_DIV   = 100_000,
  parameter int BLANK      = 1_000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             dir,
  input  logic             step,
  input  logic             load,
  output logic [OFS_W-1:0] offset,
  output logic [1:0]       digit_sel,
  output logic [3:0]       anode,
  output logic             blank
);

  localparam int SCR_W =
    (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int SCN_W =
    (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCN_W-1:0] BLANK_C =
    SCN_W'(BLANK);

  state_t state_q;
  state_t state_d;

  logic             in_run;
  logic             scroll_tc;
  logic             scan_tc;
  logic [SCR_W-1:0] unused_scroll_cnt;
  logic [SCN_W-1:0] scan_cnt;
  logic             pending;
  logic             frame;
  logic             req;
  logic             commit;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_STOP: if (run)  state_d = ST_RUN;
      ST_RUN:  if (!run) state_d = ST_STOP;
      default: state_d = ST_STOP;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_STOP;
    else       state_q <= state_d;
  end

  assign in_run = (state_q == ST_RUN);

  // Prescaler is pinned at 0 outside RUN so a fresh
  // RUN entry always waits a full SCROLL_DIV period.
  tick_div #(.N(SCROLL_DIV)) u_scroll (
    .clk   (clk),
    .reset (reset),
    .en    (in_run),
    .clr   (load || !in_run),
    .cnt   (unused_scroll_cnt),
    .tc    (scroll_tc)
  );

  tick_div #(.N(SCAN_DIV)) u_scan (
    .clk   (clk),
    .reset (reset),
    .en    (1'b1),
    .clr   (1'b0),
    .cnt   (scan_cnt),
    .tc    (scan_tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)        digit_sel <= 2'd0;
    else if (scan_tc) digit_sel <= digit_sel + 2'd1;
  end

  assign frame  = scan_tc && (digit_sel == 2'd3);
  assign commit = frame && pending;
  assign req    = in_run ? scroll_tc : step;

  // A request landing on the committing edge is
  // dropped: pending is still 1 before that edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       pending <= 1'b0;
    else if (load)   pending <= 1'b0;
    else if (commit) pending <= 1'b0;
    else if (req)    pending <= 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      offset <= '0;
    end else if (load) begin
      offset <= '0;
    end else if (commit) begin
      offset <= dir ? offset - 1'b1
                    : offset + 1'b1;
    end
  end

  always_comb begin
    blank = (scan_cnt < BLANK_C);
    anode = ANODE_OFF;
    if (!blank) begin
      anode = ~(4'b0001 << digit_sel);
    end
  end

endmodule
